input_route_ctrl: RTL and testbench
===================================

// Module: input_route_ctrl
// PURPOSE
//  Input-port controller sitting directly downstream of the router input FIFO.
//  Pops flits via the FIFO's rd_en / one-cycle-late fifo_out, buffers them in a
//  2-entry output queue, computes the XY route from head flits, and holds that
//  route (wormhole) until the tail flit is granted by the switch allocator.
// PARAMETERS
//  NUM_BITS  8  flit width; must be >= 2+2*COORD_W
//  COORD_W   3  bits per X/Y coordinate
//  CUR_X     0  this router's X coordinate
//  CUR_Y     0  this router's Y coordinate
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  fifo_empty   in   1         input FIFO empty flag
//  fifo_rd_en   out  1         pop request to input FIFO (combinational)
//  fifo_data    in   NUM_BITS  FIFO fifo_out; valid cycle after fifo_rd_en
//  out_flit     out  NUM_BITS  flit at queue head
//  out_valid    out  1         out_flit valid and requesting
//  out_req      out  5         one-hot port {LOCAL,SOUTH,NORTH,WEST,EAST}
//  out_grant    in   1         allocator accepts out_flit this cycle
//  out_tail     out  1         out_flit ends packet (type TAIL or SINGLE)
//  err_proto    out  1         one-cycle pulse on flit-type protocol error
// BEHAVIOUR
//  Flit format: [NUM_BITS-1:NUM_BITS-2] type: 01 HEAD, 00 BODY, 10 TAIL,
//   11 SINGLE. Head: dest_x = [2*COORD_W-1:COORD_W], dest_y = [COORD_W-1:0].
//  Reset (rst_n=0, async): queue empty, rd_pend=0, state IDLE, route_reg=0;
//   outputs fifo_rd_en=0, out_valid=0, out_req=0, out_flit=0, out_tail=0,
//   err_proto=0. FIFO shares rst_n; no in-flight read survives reset.
//  Pop: consume = out_valid & out_grant, or drop (see errors).
//   occ = queue_count + rd_pend - consume.
//   fifo_rd_en = !fifo_empty & (occ < 2). rd_pend <= fifo_rd_en.
//   If rd_pend, fifo_data is written to queue tail that edge. Never overflows.
//  Latency: fifo_empty low at cycle 0 -> fifo_rd_en cycle 0 -> out_valid,
//   out_req cycle 1. Sustained throughput 1 flit/cycle with out_grant held 1.
//  Route (combinational from queue-head head flit):
//   dest_x>CUR_X EAST; dest_x<CUR_X WEST; else dest_y>CUR_Y NORTH;
//   dest_y<CUR_Y SOUTH; else LOCAL. Unsigned compares, COORD_W bits.
//  FSM: IDLE (expect HEAD/SINGLE), PKT (route_reg locked).
//   IDLE, head=HEAD: out_req=computed route; on grant latch route_reg -> PKT.
//   IDLE, head=SINGLE: out_req=computed route; on grant stay IDLE.
//   PKT, head=BODY: out_req=route_reg; on grant stay PKT.
//   PKT, head=TAIL: out_req=route_reg; on grant -> IDLE.
//  out_req=0 whenever out_valid=0. out_flit/out_req stable until granted.
//  out_grant with out_valid=0: ignored, no state change.
//  Errors (err_proto pulses the cycle the flit is at queue head):
//   IDLE, BODY/TAIL at head: flit dropped (popped, out_valid=0), stay IDLE.
//   PKT, HEAD/SINGLE at head: treated as new packet in IDLE (route recomputed,
//   out_valid=1); old packet abandoned.
//  Reset mid-packet: FSM to IDLE, queued flits discarded.
// TESTING
//  CUR=(1,1); push HEAD dest(3,1), BODY, TAIL; grant held 1 -> out_req=00001
//   on 3 consecutive cycles from cycle 1, out_tail=1 on third, FSM back IDLE.
//  SINGLE dest(1,1) -> out_req=10000 (LOCAL), out_tail=1, one cycle.
//  HEAD dest(1,0), out_grant=0 for 5 cycles -> out_req=01000 stable, queue
//   fills to 2, fifo_rd_en=0 while occ=2; release grant -> no loss/reorder.
//  BODY in IDLE -> err_proto=1 one cycle, out_valid=0, flit dropped.
//  HEAD dest(0,1) then HEAD dest(2,1) without TAIL -> second req=00001,
//   err_proto=1 when second HEAD at queue head.
//  Drop rst_n mid-packet -> all outputs 0 immediately; after release, next HEAD
//   routed fresh.

Source files
------------

// File: rtl/input_route_ctrl_if.sv
// Router input-port bundle: FIFO pop side plus switch-allocator request side.
// The controller takes the master view; the FIFO/allocator environment takes slave.
interface input_route_ctrl_if #(
    parameter int NUM_BITS = 8
);
    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [NUM_BITS-1:0] fifo_data;
    logic [NUM_BITS-1:0] out_flit;
    logic                out_valid;
    logic [4:0]          out_req;
    logic                out_grant;
    logic                out_tail;
    logic                err_proto;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_grant,
        output fifo_rd_en,
        output out_flit,
        output out_valid,
        output out_req,
        output out_tail,
        output err_proto
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_grant,
        input  fifo_rd_en,
        input  out_flit,
        input  out_valid,
        input  out_req,
        input  out_tail,
        input  err_proto
    );
endinterface

// File: rtl/input_route_ctrl.sv
// Input-port controller: pops the input FIFO into a 2-entry queue, XY-routes heads, holds route to tail.
// Latency: FIFO pop cycle -> out_valid next cycle (bypass); pops stall while queue + in-flight read reach 2.
module input_route_ctrl #(
    parameter int NUM_BITS = 8,
    parameter int COORD_W  = 3,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input_route_ctrl_if.master  bus
);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [4:0] P_EAST  = 5'b00001;
    localparam logic [4:0] P_WEST  = 5'b00010;
    localparam logic [4:0] P_NORTH = 5'b00100;
    localparam logic [4:0] P_SOUTH = 5'b01000;
    localparam logic [4:0] P_LOCAL = 5'b10000;

    localparam logic [COORD_W-1:0] CX = CUR_X[COORD_W-1:0];
    localparam logic [COORD_W-1:0] CY = CUR_Y[COORD_W-1:0];

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] q_dat [2];
    logic [1:0]          q_cnt;
    logic                rd_pend;
    logic [4:0]          route_reg;
    logic                err_seen;

    logic                head_vld;
    logic [NUM_BITS-1:0] head_dat;
    logic [1:0]          head_type;
    logic [COORD_W-1:0]  dest_x, dest_y;
    logic [4:0]          calc_route;

    logic                valid_c;
    logic [4:0]          req_c;
    logic                err_c;
    logic                drop;
    logic                route_ld;
    logic                pop;
    logic [2:0]          occ;

    logic [NUM_BITS-1:0] t0, t1;
    logic [1:0]          tcnt;

    // An empty queue with a read in flight presents the FIFO output directly.
    assign head_vld  = (q_cnt != 2'd0) | rd_pend;
    assign head_dat  = (q_cnt != 2'd0) ? q_dat[0] : bus.fifo_data;
    assign head_type = head_dat[NUM_BITS-1 -: 2];
    assign dest_x    = head_dat[2*COORD_W-1:COORD_W];
    assign dest_y    = head_dat[COORD_W-1:0];

    always_comb begin
        calc_route = P_LOCAL;
        if (dest_x > CX)      calc_route = P_EAST;
        else if (dest_x < CX) calc_route = P_WEST;
        else if (dest_y > CY) calc_route = P_NORTH;
        else if (dest_y < CY) calc_route = P_SOUTH;
    end

    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        req_c     = 5'd0;
        err_c     = 1'b0;
        drop      = 1'b0;
        route_ld  = 1'b0;
        if (head_vld) begin
            if (head_type == T_HEAD || head_type == T_SINGLE) begin
                // In PKT a fresh head abandons the open packet and restarts routing.
                err_c   = (state == ST_PKT);
                valid_c = 1'b1;
                req_c   = calc_route;
                if (bus.out_grant) begin
                    if (head_type == T_HEAD) begin
                        state_nxt = ST_PKT;
                        route_ld  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end else if (state == ST_IDLE) begin
                err_c = 1'b1;
                drop  = 1'b1;
            end else begin
                valid_c = 1'b1;
                req_c   = route_reg;
                if (bus.out_grant && head_type == T_TAIL) state_nxt = ST_IDLE;
            end
        end
    end

    assign pop = (valid_c & bus.out_grant) | drop;
    assign occ = {1'b0, q_cnt} + {2'b00, rd_pend} - {2'b00, pop};

    assign bus.fifo_rd_en = rst_n & ~bus.fifo_empty & (occ < 3'd2);
    assign bus.out_valid  = valid_c;
    assign bus.out_req    = req_c;
    assign bus.out_flit   = valid_c ? head_dat : '0;
    assign bus.out_tail   = valid_c & head_type[1];
    assign bus.err_proto  = err_c & ~err_seen;

    // Append the in-flight read, then retire the head; the pop gate keeps tcnt <= 2.
    always_comb begin
        t0   = q_dat[0];
        t1   = q_dat[1];
        tcnt = q_cnt;
        if (rd_pend) begin
            if (q_cnt == 2'd0) t0 = bus.fifo_data;
            else               t1 = bus.fifo_data;
            tcnt = q_cnt + 2'd1;
        end
        if (pop) begin
            t0   = t1;
            tcnt = tcnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            q_dat[0]  <= '0;
            q_dat[1]  <= '0;
            q_cnt     <= 2'd0;
            rd_pend   <= 1'b0;
            route_reg <= 5'd0;
            err_seen  <= 1'b0;
        end else begin
            state    <= state_nxt;
            q_dat[0] <= t0;
            q_dat[1] <= t1;
            q_cnt    <= tcnt;
            rd_pend  <= bus.fifo_rd_en;
            if (route_ld) route_reg <= calc_route;
            // A stalled errant head reports once, not every cycle it waits.
            if (pop || !head_vld) err_seen <= 1'b0;
            else if (err_c)       err_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_route_ctrl.sv
// Directed bench for input_route_ctrl at router (1,1) with a behavioural one-cycle-late FIFO.
module tb_input_route_ctrl;

    localparam int NB = 8;
    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SINGLE = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    input_route_ctrl_if #(.NUM_BITS(NB)) bus ();

    input_route_ctrl #(
        .NUM_BITS(NB),
        .COORD_W (3),
        .CUR_X   (1),
        .CUR_Y   (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [NB-1:0] fq[$];
    logic rd_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] flit(input logic [1:0] t, input int x, input int y);
        logic [2:0] xs, ys;
        xs = x[2:0];
        ys = y[2:0];
        return {t, xs, ys};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] req,
                           input logic tl, input logic [NB-1:0] f);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        check({tag, "_req"},   {27'd0, bus.out_req},   {27'd0, req});
        check({tag, "_tail"},  {31'd0, bus.out_tail},  {31'd0, tl});
        check({tag, "_flit"},  {24'd0, bus.out_flit},  {24'd0, f});
    endtask

    // FIFO model: data for a pop seen in cycle N appears shortly after the next edge.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen && fq.size() > 0) bus.fifo_data = fq.pop_front();
            bus.fifo_empty = (fq.size() == 0);
        end
    end

    always @(negedge clk) rd_seen = bus.fifo_rd_en;

    initial begin
        rst_n = 1'b0;
        bus.out_grant = 1'b0;
        step();
        chk_out("rst", 1'b0, 5'd0, 1'b0, 8'd0);
        check("rst_err", {31'd0, bus.err_proto}, 32'd0);
        check("rst_rden", {31'd0, bus.fifo_rd_en}, 32'd0);
        rst_n = 1'b1;
        step();

        // HEAD/BODY/TAIL eastbound with grant held
        bus.out_grant = 1'b1;
        fq.push_back(flit(HEAD, 3, 1));
        fq.push_back(flit(BODY, 6, 2));
        fq.push_back(flit(TAIL, 0, 7));
        step();
        check("p1_c0_rden", {31'd0, bus.fifo_rd_en}, 32'd1);
        check("p1_c0_valid", {31'd0, bus.out_valid}, 32'd0);
        step(); chk_out("p1_c1", 1'b1, 5'b00001, 1'b0, flit(HEAD, 3, 1));
        step(); chk_out("p1_c2", 1'b1, 5'b00001, 1'b0, flit(BODY, 6, 2));
        step(); chk_out("p1_c3", 1'b1, 5'b00001, 1'b1, flit(TAIL, 0, 7));
        step(); chk_out("p1_c4", 1'b0, 5'd0, 1'b0, 8'd0);

        // SINGLE to self -> LOCAL
        fq.push_back(flit(SINGLE, 1, 1));
        step();
        step(); chk_out("s_c1", 1'b1, 5'b10000, 1'b1, flit(SINGLE, 1, 1));
        check("s_c1_err", {31'd0, bus.err_proto}, 32'd0);
        step(); chk_out("s_c2", 1'b0, 5'd0, 1'b0, 8'd0);

        // Southbound packet stalled by the allocator
        bus.out_grant = 1'b0;
        fq.push_back(flit(HEAD, 1, 0));
        fq.push_back(flit(BODY, 5, 5));
        fq.push_back(flit(BODY, 2, 3));
        fq.push_back(flit(TAIL, 4, 6));
        step();
        check("bp_c0_rden", {31'd0, bus.fifo_rd_en}, 32'd1);
        step();
        chk_out("bp_c1", 1'b1, 5'b01000, 1'b0, flit(HEAD, 1, 0));
        check("bp_c1_rden", {31'd0, bus.fifo_rd_en}, 32'd1);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk_out($sformatf("bp_c%0d", c), 1'b1, 5'b01000, 1'b0, flit(HEAD, 1, 0));
            check($sformatf("bp_c%0d_rden", c), {31'd0, bus.fifo_rd_en}, 32'd0);
        end
        step();
        bus.out_grant = 1'b1;
        chk_out("bp_c6", 1'b1, 5'b01000, 1'b0, flit(HEAD, 1, 0));
        step(); chk_out("bp_c7", 1'b1, 5'b01000, 1'b0, flit(BODY, 5, 5));
        step(); chk_out("bp_c8", 1'b1, 5'b01000, 1'b0, flit(BODY, 2, 3));
        step(); chk_out("bp_c9", 1'b1, 5'b01000, 1'b1, flit(TAIL, 4, 6));
        step(); chk_out("bp_c10", 1'b0, 5'd0, 1'b0, 8'd0);

        // Stray BODY while idle is dropped
        fq.push_back(flit(BODY, 3, 3));
        step();
        step();
        chk_out("drop_c1", 1'b0, 5'd0, 1'b0, 8'd0);
        check("drop_c1_err", {31'd0, bus.err_proto}, 32'd1);
        step();
        check("drop_c2_err", {31'd0, bus.err_proto}, 32'd0);
        check("drop_c2_valid", {31'd0, bus.out_valid}, 32'd0);
        check("drop_c2_rden", {31'd0, bus.fifo_rd_en}, 32'd0);

        // HEAD west then HEAD east without a TAIL
        fq.push_back(flit(HEAD, 0, 1));
        fq.push_back(flit(HEAD, 2, 1));
        step();
        step();
        chk_out("hh_c1", 1'b1, 5'b00010, 1'b0, flit(HEAD, 0, 1));
        check("hh_c1_err", {31'd0, bus.err_proto}, 32'd0);
        step();
        chk_out("hh_c2", 1'b1, 5'b00001, 1'b0, flit(HEAD, 2, 1));
        check("hh_c2_err", {31'd0, bus.err_proto}, 32'd1);
        step();
        check("hh_c3_valid", {31'd0, bus.out_valid}, 32'd0);
        check("hh_c3_err", {31'd0, bus.err_proto}, 32'd0);
        fq.push_back(flit(TAIL, 0, 0));
        step();
        step();
        chk_out("hh_tail", 1'b1, 5'b00001, 1'b1, flit(TAIL, 0, 0));
        check("hh_tail_err", {31'd0, bus.err_proto}, 32'd0);
        step();
        check("hh_end_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a northbound packet
        bus.out_grant = 1'b0;
        fq.push_back(flit(HEAD, 1, 2));
        fq.push_back(flit(BODY, 7, 7));
        step();
        step(); chk_out("rm_c1", 1'b1, 5'b00100, 1'b0, flit(HEAD, 1, 2));
        step(); chk_out("rm_c2", 1'b1, 5'b00100, 1'b0, flit(HEAD, 1, 2));
        #1;
        rst_n = 1'b0;
        fq.delete();
        #1;
        chk_out("rm_rst", 1'b0, 5'd0, 1'b0, 8'd0);
        check("rm_rst_err", {31'd0, bus.err_proto}, 32'd0);
        check("rm_rst_rden", {31'd0, bus.fifo_rd_en}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        bus.out_grant = 1'b1;
        fq.push_back(flit(HEAD, 1, 0));
        fq.push_back(flit(TAIL, 2, 2));
        step();
        step();
        chk_out("rm_h", 1'b1, 5'b01000, 1'b0, flit(HEAD, 1, 0));
        check("rm_h_err", {31'd0, bus.err_proto}, 32'd0);
        step();
        chk_out("rm_t", 1'b1, 5'b01000, 1'b1, flit(TAIL, 2, 2));
        check("rm_t_err", {31'd0, bus.err_proto}, 32'd0);
        step();
        chk_out("rm_end", 1'b0, 5'd0, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
